// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_pkg
// Description : Shared opcodes, FSM state encoding and width default for the
//               SPI-to-RAM serial front end.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam int SPI_ADDR_W = 8;

    // Frame opcodes carried in the two MSBs of every command word
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_SEND      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_ctrl_if
// Description : SPI pins plus the RAM-side receive/transmit handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_ctrl_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [ADDR_W+1:0] rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, busy
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : MSB-first serial-in/serial-out shifter with clear and load.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o
);
    logic [WIDTH-1:0] sr_q;

    // Clear dominates load, load dominates shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clr_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_en_i) begin
            sr_q <= {sr_q[WIDTH-2:0], sin_i};
        end
    end

    assign q_o    = sr_q;
    assign sout_o = sr_q[WIDTH-1];
endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_ctrl
// Description : SPI slave sequencer: deserialises command frames for the RAM
//               and serialises read data back on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_slave_ctrl_if.slave        bus
);
    localparam int               FRAME_W      = ADDR_W + 2;
    localparam logic [CNT_W-1:0] C_LAST_BIT   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] C_FRAME_DONE = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               addr_rcvd_q, addr_rcvd_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               busy_q;

    logic               w_rx_clr, w_rx_shift;
    logic               w_tx_clr, w_tx_load, w_tx_shift;
    logic [FRAME_W-1:0] w_rx_q;
    logic               w_rx_sout;
    logic [ADDR_W-1:0]  w_tx_q;
    logic               w_tx_sout;
    logic [FRAME_W-1:0] w_frame;
    logic [1:0]         w_op;
    logic               w_unused;

    // The frame is complete on the edge that samples its last bit
    assign w_frame  = {w_rx_q[FRAME_W-2:0], bus.mosi};
    assign w_op     = w_frame[FRAME_W-1 -: 2];
    assign w_unused = &{1'b0, w_rx_sout, w_rx_q[FRAME_W-1], w_tx_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_rcvd_d = addr_rcvd_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        w_rx_clr    = 1'b0;
        w_rx_shift  = 1'b0;
        w_tx_clr    = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_shift  = 1'b0;

        if (state_q != ST_IDLE && bus.ss_n) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            w_rx_clr = 1'b1;
            w_tx_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    w_rx_clr = 1'b1;
                    w_tx_clr = 1'b1;
                    cnt_d    = '0;
                    if (!bus.ss_n) begin
                        state_d = ST_CHK_CMD;
                    end
                end
                ST_CHK_CMD: begin
                    w_rx_shift = 1'b1;
                    cnt_d      = C_ONE;
                    if (!bus.mosi) begin
                        state_d = ST_WRITE;
                    end else if (addr_rcvd_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q < C_FRAME_DONE) begin
                        w_rx_shift = 1'b1;
                        cnt_d      = cnt_q + C_ONE;
                        if (cnt_q == C_LAST_BIT) begin
                            rx_data_d  = w_frame;
                            rx_valid_d = 1'b1;
                            if (w_op == OP_RD_ADDR) begin
                                addr_rcvd_d = 1'b1;
                            end else if (w_op == OP_RD_DATA) begin
                                addr_rcvd_d = 1'b0;
                            end
                            // Only a read-data frame after a loaded address returns data
                            if (state_q == ST_READ_DATA && w_op == OP_RD_DATA) begin
                                state_d = ST_SEND;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                ST_SEND: begin
                    // cnt_q doubles as the "read data captured" flag here
                    if (cnt_q == '0) begin
                        if (bus.tx_valid) begin
                            w_tx_load = 1'b1;
                            cnt_d     = C_ONE;
                        end
                    end else begin
                        w_tx_shift = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_rcvd_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_rcvd_q <= addr_rcvd_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    spi_shift_reg #(.WIDTH(FRAME_W)) u_rx_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (w_rx_clr),
        .load_i     (1'b0),
        .shift_en_i (w_rx_shift),
        .sin_i      (bus.mosi),
        .din_i      ({FRAME_W{1'b0}}),
        .q_o        (w_rx_q),
        .sout_o     (w_rx_sout)
    );

    // Zeros shift in behind the data so MISO falls to 0 after the last bit
    spi_shift_reg #(.WIDTH(ADDR_W)) u_tx_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (w_tx_clr),
        .load_i     (w_tx_load),
        .shift_en_i (w_tx_shift),
        .sin_i      (1'b0),
        .din_i      (bus.tx_data),
        .q_o        (w_tx_q),
        .sout_o     (w_tx_sout)
    );

    assign bus.miso     = w_tx_sout;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_ctrl
// Description : Randomised bench for spi_slave_ctrl with a transaction-level
//               reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_ctrl;
    import spi_ram_pkg::*;

    localparam int N_MAX = 8192;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_slave_ctrl_if #(.ADDR_W(8)) bus_if ();

    spi_slave_ctrl #(.ADDR_W(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // Per-cycle stimulus and expected outputs, indexed by absolute cycle
    logic       st_rst  [N_MAX];
    logic       st_ss   [N_MAX];
    logic       st_mosi [N_MAX];
    logic       st_txv  [N_MAX];
    logic [7:0] st_txd  [N_MAX];
    logic       exp_rxv [N_MAX];
    logic       exp_miso[N_MAX];
    logic       exp_busy[N_MAX];
    logic       exp_addr[N_MAX];
    logic [9:0] exp_rxd [N_MAX];

    typedef struct {
        int         cyc;
        int         kind;
        logic [9:0] val;
    } pin_t;
    pin_t pinq[$];

    int         wr_ptr;
    logic [9:0] m_rxd;
    logic       m_addr;
    int         n_checks;
    int         n_pass;
    bit         built;

    task automatic chk(input string name, input int k, input logic [9:0] act, input logic [9:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp_v);
    endtask

    task automatic pin(input int cyc, input int kind, input logic [9:0] val);
        pinq.push_back('{cyc, kind, val});
    endtask

    task automatic add_idle(input int n, input bit stray);
        for (int c = 0; c < n; c++) begin
            int a;
            a = wr_ptr + c;
            st_rst[a]   = 1'b1;
            st_ss[a]    = 1'b1;
            st_mosi[a]  = 1'($urandom);
            st_txv[a]   = stray && ($urandom_range(0, 1) == 0);
            st_txd[a]   = 8'($urandom);
            exp_rxv[a]  = 1'b0;
            exp_miso[a] = 1'b0;
            exp_busy[a] = 1'b0;
            exp_addr[a] = m_addr;
            exp_rxd[a]  = m_rxd;
        end
        wr_ptr += n;
    endtask

    // One ss_n-low episode: n cycles low starting at relative cycle 0,
    // frame bit (10-c) on mosi in cycle c, optional reset at cycle rst_at.
    task automatic add_txn(input int n, input logic [9:0] frame, input int txv_at,
                           input logic [7:0] txd_at, input bit stray, input int gap,
                           input int rst_at);
        int         c0, total, n_eff, t_cap;
        bit         complete, send;
        logic [7:0] d_cap;
        logic       new_addr;
        c0    = wr_ptr;
        total = n + gap;
        n_eff = (rst_at >= 0 && rst_at < n) ? rst_at : n;
        for (int c = 0; c < total; c++) begin
            int a;
            a = c0 + c;
            st_rst[a]  = !(rst_at >= 0 && c >= rst_at && c < rst_at + 2);
            st_ss[a]   = !(c < n_eff);
            st_mosi[a] = (c >= 1 && c <= 10) ? frame[10 - c] : 1'($urandom);
            st_txv[a]  = (c == txv_at) || (stray && ($urandom_range(0, 3) == 0));
            st_txd[a]  = (c == txv_at) ? txd_at : 8'($urandom);
        end
        complete = (n_eff >= 11);
        send     = complete && (frame[9:8] == 2'b11) && m_addr;
        new_addr = m_addr;
        if (complete && frame[9:8] == 2'b10) new_addr = 1'b1;
        if (complete && frame[9:8] == 2'b11) new_addr = 1'b0;
        t_cap = -1;
        d_cap = 8'h00;
        if (send) begin
            for (int c = 11; c < n_eff; c++) begin
                if (st_txv[c0 + c]) begin
                    t_cap = c;
                    d_cap = st_txd[c0 + c];
                    break;
                end
            end
        end
        for (int c = 0; c < total; c++) begin
            int a;
            a = c0 + c;
            exp_busy[a] = (c >= 1 && c <= n_eff);
            exp_rxv[a]  = complete && (c == 11);
            exp_rxd[a]  = (complete && c >= 11) ? frame : m_rxd;
            exp_addr[a] = (complete && c >= 11) ? new_addr : m_addr;
            exp_miso[a] = 1'b0;
            if (t_cap >= 0 && c >= t_cap + 1 && c <= t_cap + 8 && c <= n_eff)
                exp_miso[a] = d_cap[7 - (c - t_cap - 1)];
            if (rst_at >= 0 && c >= rst_at) begin
                exp_busy[a] = 1'b0;
                exp_rxv[a]  = 1'b0;
                exp_rxd[a]  = 10'h000;
                exp_addr[a] = 1'b0;
                exp_miso[a] = 1'b0;
            end
        end
        if (rst_at >= 0) begin
            m_rxd  = 10'h000;
            m_addr = 1'b0;
        end else if (complete) begin
            m_rxd  = frame;
            m_addr = new_addr;
        end
        wr_ptr += total;
    endtask

    task automatic apply(input int k);
        rst_n           = st_rst[k];
        bus_if.ss_n     = st_ss[k];
        bus_if.mosi     = st_mosi[k];
        bus_if.tx_valid = st_txv[k];
        bus_if.tx_data  = st_txd[k];
    endtask

    // Compare process: every cycle, sampled on the falling edge
    initial begin
        wait (built);
        for (int k = 1; k < wr_ptr; k++) begin
            @(negedge clk);
            chk("rx_valid", k, {9'd0, bus_if.rx_valid}, {9'd0, exp_rxv[k]});
            chk("rx_data",  k, bus_if.rx_data,           exp_rxd[k]);
            chk("miso",     k, {9'd0, bus_if.miso},     {9'd0, exp_miso[k]});
            chk("busy",     k, {9'd0, bus_if.busy},     {9'd0, exp_busy[k]});
            chk("addr_rcvd", k, {9'd0, dut.addr_rcvd_q}, {9'd0, exp_addr[k]});
            while (pinq.size() > 0 && pinq[0].cyc == k) begin
                case (pinq[0].kind)
                    0:       chk("pin_rx_valid", k, {9'd0, bus_if.rx_valid}, pinq[0].val);
                    1:       chk("pin_rx_data",  k, bus_if.rx_data,          pinq[0].val);
                    2:       chk("pin_miso",     k, {9'd0, bus_if.miso},     pinq[0].val);
                    3:       chk("pin_busy",     k, {9'd0, bus_if.busy},     pinq[0].val);
                    default: chk("pin_addr_rcvd", k, {9'd0, dut.addr_rcvd_q}, pinq[0].val);
                endcase
                void'(pinq.pop_front());
            end
        end
    end

    initial begin
        int         c0;
        int         n_r, tv_r;
        logic [9:0] fr_r;
        logic [7:0] a5;
        n_checks = 0;
        n_pass   = 0;
        built    = 1'b0;
        m_rxd    = 10'h000;
        m_addr   = 1'b0;
        wr_ptr   = 1;

        // Reset state
        add_idle(3, 1'b1);
        st_rst[1] = 1'b0;
        st_rst[2] = 1'b0;
        pin(1, 3, 10'd0);
        pin(1, 1, 10'h000);
        pin(2, 2, 10'd0);

        // Write address
        c0 = wr_ptr;
        add_txn(12, 10'h02A, -1, 8'h00, 1'b0, 2, -1);
        pin(c0 + 10, 0, 10'd0);
        pin(c0 + 11, 0, 10'd1);
        pin(c0 + 11, 1, 10'h02A);
        pin(c0 + 12, 0, 10'd0);
        pin(c0 + 12, 4, 10'd0);

        // Read address, then read data returning A5
        c0 = wr_ptr;
        add_txn(12, 10'h205, -1, 8'h00, 1'b0, 2, -1);
        pin(c0 + 10, 4, 10'd0);
        pin(c0 + 11, 4, 10'd1);
        pin(c0 + 11, 1, 10'h205);
        c0 = wr_ptr;
        add_txn(24, 10'h3C7, 12, 8'hA5, 1'b0, 2, -1);
        pin(c0 + 11, 0, 10'd1);
        pin(c0 + 11, 4, 10'd0);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) pin(c0 + 13 + i, 2, {9'd0, a5[7 - i]});
        pin(c0 + 21, 2, 10'd0);
        pin(c0 + 24, 3, 10'd1);
        pin(c0 + 25, 3, 10'd0);

        // Abort after 6 bits, then the full frame
        c0 = wr_ptr;
        add_txn(7, 10'h1F0, -1, 8'h00, 1'b0, 2, -1);
        pin(c0 + 7, 3, 10'd1);
        pin(c0 + 8, 3, 10'd0);
        pin(c0 + 8, 1, 10'h3C7);
        c0 = wr_ptr;
        add_txn(11, 10'h1F0, -1, 8'h00, 1'b0, 3, -1);
        pin(c0 + 11, 0, 10'd1);
        pin(c0 + 11, 1, 10'h1F0);

        // ss_n rises as the 10th bit is sampled
        c0 = wr_ptr;
        add_txn(10, 10'h0FF, -1, 8'h00, 1'b0, 2, -1);
        pin(c0 + 11, 0, 10'd0);
        pin(c0 + 11, 1, 10'h1F0);

        // Read data with no address loaded
        c0 = wr_ptr;
        add_txn(14, 10'h300, 12, 8'h81, 1'b0, 2, -1);
        pin(c0 + 11, 1, 10'h300);
        pin(c0 + 12, 4, 10'd0);
        pin(c0 + 13, 2, 10'd0);
        pin(c0 + 14, 3, 10'd1);

        // Stray tx_valid during WRITE and IDLE
        c0 = wr_ptr;
        add_txn(13, 10'h155, 5, 8'h3C, 1'b0, 2, -1);
        pin(c0 + 6, 2, 10'd0);
        pin(c0 + 6, 3, 10'd1);
        pin(c0 + 11, 1, 10'h155);
        add_idle(4, 1'b1);

        // Reset after three bits of FF
        add_txn(12, 10'h2AB, -1, 8'h00, 1'b0, 1, -1);
        c0 = wr_ptr;
        add_txn(22, 10'h3FF, 12, 8'hFF, 1'b0, 4, 16);
        pin(c0 + 13, 2, 10'd1);
        pin(c0 + 15, 2, 10'd1);
        pin(c0 + 16, 2, 10'd0);
        pin(c0 + 16, 3, 10'd0);
        pin(c0 + 16, 1, 10'h000);
        pin(c0 + 16, 4, 10'd0);
        add_idle(6, 1'b1);

        // Randomised episodes
        for (int i = 0; i < 160 && wr_ptr < N_MAX - 80; i++) begin
            n_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : $urandom_range(11, 30);
            fr_r = 10'($urandom);
            tv_r = ($urandom_range(0, 1) == 1) ? $urandom_range(11, 20) : -1;
            add_txn(n_r, fr_r, tv_r, 8'($urandom), ($urandom_range(0, 1) == 1),
                    $urandom_range(1, 3), -1);
        end
        add_idle(3, 1'b0);

        rst_n           = 1'b1;
        bus_if.ss_n     = 1'b1;
        bus_if.mosi     = 1'b0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        built           = 1'b1;
        #2 rst_n = 1'b0;

        for (int k = 1; k < wr_ptr; k++) begin
            @(posedge clk);
            #1;
            apply(k);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
